// File: rtl/azimuth_scan_gen.sv
// Azimuth generator on the ACP clock: programmable count per revolution,
// CW/CCW rotation, bidirectional sector scan, blanking sector and revolution count.
module azimuth_scan_gen #(
  parameter int AZ_W         = 12,
  parameter int REV_W        = 16,
  parameter int DEFAULT_ACPS = 4096
) (
  input  logic             clk_ACP,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             dir,
  input  logic [AZ_W-1:0]  acp_per_rev,
  input  logic [AZ_W-1:0]  sec_start,
  input  logic [AZ_W-1:0]  sec_end,
  input  logic             blank_en,
  input  logic [AZ_W-1:0]  blank_start,
  input  logic [AZ_W-1:0]  blank_end,
  output logic [AZ_W-1:0]  azimuth,
  output logic             arp,
  output logic [REV_W-1:0] rev_count,
  output logic             scan_dir,
  output logic             blank,
  output logic             cfg_err
);

  localparam logic [AZ_W-1:0] DEF_NM1 = AZ_W'(DEFAULT_ACPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN_CW,
    RUN_CCW,
    SEEK,
    SWEEP_UP,
    SWEEP_DN
  } state_t;

  state_t          state;
  state_t          eff;
  state_t          nxt_state;
  logic [AZ_W-1:0] nm1;        // active count per revolution minus one
  logic [AZ_W-1:0] req_nm1;
  logic [AZ_W-1:0] nxt_az;
  logic            req_bad;
  logic            sec_valid;
  logic            in_sector;
  logic            nxt_arp;
  logic            lat_pt;
  logic            nxt_blank;

  always_comb begin
    req_nm1   = acp_per_rev - AZ_W'(1);   // 0 encodes 2^AZ_W, so N-1 is all ones
    req_bad   = (acp_per_rev == AZ_W'(1));
    sec_valid = (sec_start < sec_end) && (sec_end <= nm1);
    in_sector = (azimuth >= sec_start) && (azimuth <= sec_end);

    // Mode/validity changes while running re-map the behaviour of this edge,
    // so the step below always uses the mode actually requested now.
    eff = state;
    if (!mode) begin
      eff = dir ? RUN_CCW : RUN_CW;
    end else if (!sec_valid) begin
      eff = RUN_CW;
    end else begin
      case (state)
        RUN_CW, RUN_CCW:    eff = (azimuth == sec_start) ? SWEEP_UP : SEEK;
        SWEEP_UP, SWEEP_DN: if (!in_sector) eff = SEEK;
        default:            eff = state;
      endcase
    end

    nxt_state = eff;
    nxt_az    = azimuth;
    nxt_arp   = 1'b0;
    lat_pt    = 1'b0;

    if (!enable) begin
      nxt_state = IDLE;
    end else if (state == IDLE) begin
      if (!mode)
        nxt_state = dir ? RUN_CCW : RUN_CW;
      else if (!sec_valid)
        nxt_state = RUN_CW;
      else
        nxt_state = (azimuth == sec_start) ? SWEEP_UP : SEEK;
    end else begin
      case (eff)
        RUN_CW, SEEK: begin
          if (azimuth == nm1) begin
            nxt_az  = '0;
            nxt_arp = 1'b1;
            lat_pt  = 1'b1;
          end else begin
            nxt_az = azimuth + AZ_W'(1);
          end
          if (eff == SEEK && nxt_az == sec_start)
            nxt_state = SWEEP_UP;
        end
        RUN_CCW: begin
          if (azimuth == '0) begin
            nxt_az = nm1;
            lat_pt = 1'b1;
          end else begin
            nxt_az = azimuth - AZ_W'(1);
            if (nxt_az == '0) begin
              nxt_arp = 1'b1;
              lat_pt  = 1'b1;
            end
          end
        end
        SWEEP_UP: begin
          if (azimuth >= sec_end) begin
            nxt_az    = sec_end - AZ_W'(1);
            nxt_state = SWEEP_DN;
          end else begin
            nxt_az = azimuth + AZ_W'(1);
          end
        end
        SWEEP_DN: begin
          if (azimuth <= sec_start) begin
            nxt_az    = sec_start + AZ_W'(1);
            nxt_state = SWEEP_UP;
            nxt_arp   = 1'b1;
          end else begin
            nxt_az = azimuth - AZ_W'(1);
          end
        end
        default: nxt_state = IDLE;
      endcase
    end

    if (blank_start <= blank_end)
      nxt_blank = blank_en && (nxt_az >= blank_start) && (nxt_az <= blank_end);
    else
      nxt_blank = blank_en && ((nxt_az >= blank_start) || (nxt_az <= blank_end));
  end

  always_ff @(posedge clk_ACP or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      azimuth   <= '0;
      arp       <= 1'b0;
      rev_count <= '0;
      scan_dir  <= 1'b0;
      blank     <= 1'b0;
      cfg_err   <= 1'b0;
      nm1       <= DEF_NM1;
    end else begin
      state    <= nxt_state;
      azimuth  <= nxt_az;
      arp      <= nxt_arp;
      scan_dir <= (nxt_state == RUN_CCW) || (nxt_state == SWEEP_DN);
      blank    <= nxt_blank;
      if (nxt_arp)
        rev_count <= rev_count + REV_W'(1);
      if (req_bad || (mode && !sec_valid))
        cfg_err <= 1'b1;
      // A new count is only taken if the azimuth it leaves behind is in range.
      if (!req_bad && (state == IDLE || lat_pt) && (nxt_az <= req_nm1))
        nm1 <= req_nm1;
    end
  end

endmodule

// File: tb/tb_azimuth_scan_gen.sv
// Directed, table-driven bench for azimuth_scan_gen with hand-computed expectations.
module tb_azimuth_scan_gen;

  logic        clk_ACP = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        dir = 1'b0;
  logic [11:0] acp_per_rev = '0;
  logic [11:0] sec_start = 12'd10;
  logic [11:0] sec_end = 12'd14;
  logic        blank_en = 1'b0;
  logic [11:0] blank_start = 12'd4094;
  logic [11:0] blank_end = 12'd2;
  logic [11:0] azimuth;
  logic        arp;
  logic [15:0] rev_count;
  logic        scan_dir;
  logic        blank;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  azimuth_scan_gen #(.AZ_W(12), .REV_W(16), .DEFAULT_ACPS(4096)) dut (
    .clk_ACP(clk_ACP), .rst(rst), .enable(enable), .mode(mode), .dir(dir),
    .acp_per_rev(acp_per_rev), .sec_start(sec_start), .sec_end(sec_end),
    .blank_en(blank_en), .blank_start(blank_start), .blank_end(blank_end),
    .azimuth(azimuth), .arp(arp), .rev_count(rev_count), .scan_dir(scan_dir),
    .blank(blank), .cfg_err(cfg_err)
  );

  always #5 clk_ACP = ~clk_ACP;

  typedef struct {
    bit en, md, dr;
    int acp, ss, se;
    bit ben;
    int bs, be, n;
    int az;
    bit arp;
    int rev;
    bit sd, blk, cfg;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit en, bit md, bit dr, int acp, int ss, int se,
                              bit ben, int bs, int be, int n, int az, bit ap,
                              int rev, bit sd, bit blk, bit cfg);
    vec_t v;
    v = '{en, md, dr, acp, ss, se, ben, bs, be, n, az, ap, rev, sd, blk, cfg};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int az, input bit ap, input int rev,
                         input bit sd, input bit blk, input bit cfg);
    chk({tag, ".azimuth"}, int'(azimuth), az);
    chk({tag, ".arp"}, int'(arp), int'(ap));
    chk({tag, ".rev_count"}, int'(rev_count), rev);
    chk({tag, ".scan_dir"}, int'(scan_dir), int'(sd));
    chk({tag, ".blank"}, int'(blank), int'(blk));
    chk({tag, ".cfg_err"}, int'(cfg_err), int'(cfg));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_ACP);
    @(negedge clk_ACP);
  endtask

  task automatic pulse_reset();
    @(negedge clk_ACP);
    #2 rst = 1'b1;
    #1;
    @(negedge clk_ACP);
    rst = 1'b0;
  endtask

  initial begin
    //  en md dr acp  ss se ben bs   be   n     az   arp rev sd blk cfg
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 1,    0,    0, 0,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 4095, 4095, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 1,    0,    1, 1,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 1,    1,    0, 1,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 99,   100,  0, 1,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 1,    101,  0, 1,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 3994, 4095, 0, 1,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 1,    0,    1, 2,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 359,  359,  0, 2,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 1,    0,    1, 3,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 360,  0,    1, 4,  0, 0, 0);
    add(1, 0, 0, 360, 10, 14, 0, 4094, 2, 2,    2,    0, 4,  0, 0, 0);
    add(1, 0, 1, 360, 10, 14, 0, 4094, 2, 1,    1,    0, 4,  1, 0, 0);
    add(1, 0, 1, 0,   10, 14, 0, 4094, 2, 1,    0,    1, 5,  1, 0, 0);
    add(1, 0, 1, 0,   10, 14, 0, 4094, 2, 1,    4095, 0, 5,  1, 0, 0);
    add(1, 0, 1, 0,   10, 14, 1, 4094, 2, 1,    4094, 0, 5,  1, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 4094, 2, 1,    4095, 0, 5,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 4094, 2, 1,    0,    1, 6,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 4094, 2, 2,    2,    0, 6,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 4094, 2, 1,    3,    0, 6,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 697,  700,  0, 6,  0, 0, 0);
    add(0, 0, 0, 0,   10, 14, 1, 690, 710, 5,   700,  0, 6,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 690, 710, 1,   700,  0, 6,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 1, 690, 710, 1,   701,  0, 6,  0, 1, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 3394, 4095, 0, 6,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 1,    0,    1, 7,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 5,    5,    0, 7,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    6,    0, 7,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 4,    10,   0, 7,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 4,    14,   0, 7,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    13,   0, 7,  1, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 3,    10,   0, 7,  1, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    11,   1, 8,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 3,    14,   0, 8,  0, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    13,   0, 8,  1, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 3,    10,   0, 8,  1, 0, 0);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    11,   1, 9,  0, 0, 0);
    add(1, 0, 0, 0,   10, 14, 0, 4094, 2, 1,    12,   0, 9,  0, 0, 0);
    add(1, 1, 0, 0,   14, 10, 0, 4094, 2, 1,    13,   0, 9,  0, 0, 1);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    14,   0, 9,  0, 0, 1);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 4081, 4095, 0, 9,  0, 0, 1);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 1,    0,    1, 10, 0, 0, 1);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 10,   10,   0, 10, 0, 0, 1);
    add(1, 1, 0, 0,   10, 14, 0, 4094, 2, 2,    12,   0, 10, 0, 0, 1);

    #1 rst = 1'b1;
    #2 chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_ACP);
    rst = 1'b0;

    foreach (vq[i]) begin
      enable      = vq[i].en;
      mode        = vq[i].md;
      dir         = vq[i].dr;
      acp_per_rev = 12'(vq[i].acp);
      sec_start   = 12'(vq[i].ss);
      sec_end     = 12'(vq[i].se);
      blank_en    = vq[i].ben;
      blank_start = 12'(vq[i].bs);
      blank_end   = 12'(vq[i].be);
      step(vq[i].n);
      chk_all($sformatf("v%0d", i), vq[i].az, vq[i].arp, vq[i].rev,
              vq[i].sd, vq[i].blk, vq[i].cfg);
    end

    // Asynchronous reset in the middle of a sweep, sampled before any clock edge.
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    enable = 1'b1; mode = 1'b0; dir = 1'b0; acp_per_rev = 12'd1;
    sec_start = 12'd10; sec_end = 12'd14; blank_en = 1'b0;
    @(negedge clk_ACP);
    rst = 1'b0;

    // Illegal count of 1: flag raised, revolution length stays 4096.
    step(1);
    chk_all("bad_n.first", 0, 0, 0, 0, 0, 1);
    step(4095);
    chk("bad_n.az_top", int'(azimuth), 4095);
    step(1);
    chk_all("bad_n.wrap", 0, 1, 1, 0, 0, 1);

    // Small count latched in IDLE: N=3, CW.
    acp_per_rev = 12'd3;
    pulse_reset();
    chk("n3.cfg_cleared", int'(cfg_err), 0);
    step(1);
    chk("n3.start", int'(azimuth), 0);
    step(2);
    chk("n3.top", int'(azimuth), 2);
    step(1);
    chk_all("n3.wrap", 0, 1, 1, 0, 0, 0);

    // Minimum count N=2, CCW: wrap 0->1 has no arp, 1->0 has arp.
    acp_per_rev = 12'd2; dir = 1'b1;
    pulse_reset();
    step(1);
    chk_all("n2.start", 0, 0, 0, 1, 0, 0);
    step(1);
    chk_all("n2.ccw_wrap", 1, 0, 0, 1, 0, 0);
    step(1);
    chk_all("n2.arp", 0, 1, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
